// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, x/y raster counters,
// registered sync/blank/coordinate outputs and line/frame strobes, all mutually aligned.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 10,
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   output logic          pix_en_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          video_on_o,
   output logic [CW-1:0] x_o,
   output logic [CW-1:0] y_o,
   output logic          line_tick_o,
   output logic          frame_tick_o,
   output logic [DW-1:0] div_cnt_o
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic          hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;
   logic          lt_q, lt_d, ft_q, ft_d;
   logic          pix_en;
   logic          x_last, y_last;

   assign pix_en = en_i && (div_q == DW'(CLK_DIV - 1));
   assign x_last = (x_q == CW'(H_TOTAL - 1));
   assign y_last = (y_q == CW'(V_TOTAL - 1));

   // Sync and blanking decode from next-state coordinates so they land with x/y.
   always_comb begin
      div_d = div_q;
      x_d   = x_q;
      y_d   = y_q;
      if (en_i) begin
         div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
      end
      if (pix_en) begin
         if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + CW'(1);
         end else begin
            x_d = x_q + CW'(1);
         end
      end
      hs_d  = (x_d >= CW'(HS_START) && x_d < CW'(HS_END)) ? HS_POL : ~HS_POL;
      vs_d  = (y_d >= CW'(VS_START) && y_d < CW'(VS_END)) ? VS_POL : ~VS_POL;
      vid_d = (x_d < CW'(H_ACTIVE)) && (y_d < CW'(V_ACTIVE));
      lt_d  = pix_en && x_last;
      ft_d  = pix_en && x_last && y_last;
   end

   // Reset parks the raster on its last pixel so the first strobe lands on (0,0).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         x_q   <= CW'(H_TOTAL - 1);
         y_q   <= CW'(V_TOTAL - 1);
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         vid_q <= 1'b0;
         lt_q  <= 1'b0;
         ft_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         vid_q <= vid_d;
         lt_q  <= lt_d;
         ft_q  <= ft_d;
      end
   end

   assign pix_en_o     = pix_en;
   assign hsync_o      = hs_q;
   assign vsync_o      = vs_q;
   assign video_on_o   = vid_q;
   assign x_o          = x_q;
   assign y_o          = y_q;
   assign line_tick_o  = lt_q;
   assign frame_tick_o = ft_q;
   assign div_cnt_o    = div_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480/div4, tiny div1 active-high,
// small div2) driven through directed timelines; a cycle-stamped scoreboard checks outputs.
module tb_vga_timing_gen;

   typedef struct {
      int         inst;
      int         cyc;
      string      name;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] div;
      logic [5:0] f;   // {video_on, hsync, vsync, line_tick, frame_tick, pix_en}
   } rec_t;

   rec_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   logic clk;
   logic rst_n [3];
   logic en    [3];
   logic [9:0] x_w [3];
   logic [9:0] y_w [3];
   logic [1:0] d_w [3];
   logic vid_w [3];
   logic hs_w  [3];
   logic vs_w  [3];
   logic lt_w  [3];
   logic ft_w  [3];
   logic pe_w  [3];
   logic d_b, d_c;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   vga_timing_gen u_a (
      .clk_i(clk), .rst_ni(rst_n[0]), .en_i(en[0]),
      .pix_en_o(pe_w[0]), .hsync_o(hs_w[0]), .vsync_o(vs_w[0]), .video_on_o(vid_w[0]),
      .x_o(x_w[0]), .y_o(y_w[0]), .line_tick_o(lt_w[0]), .frame_tick_o(ft_w[0]),
      .div_cnt_o(d_w[0])
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
   ) u_b (
      .clk_i(clk), .rst_ni(rst_n[1]), .en_i(en[1]),
      .pix_en_o(pe_w[1]), .hsync_o(hs_w[1]), .vsync_o(vs_w[1]), .video_on_o(vid_w[1]),
      .x_o(x_w[1]), .y_o(y_w[1]), .line_tick_o(lt_w[1]), .frame_tick_o(ft_w[1]),
      .div_cnt_o(d_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)
   ) u_c (
      .clk_i(clk), .rst_ni(rst_n[2]), .en_i(en[2]),
      .pix_en_o(pe_w[2]), .hsync_o(hs_w[2]), .vsync_o(vs_w[2]), .video_on_o(vid_w[2]),
      .x_o(x_w[2]), .y_o(y_w[2]), .line_tick_o(lt_w[2]), .frame_tick_o(ft_w[2]),
      .div_cnt_o(d_c)
   );

   assign d_w[1] = {1'b0, d_b};
   assign d_w[2] = {1'b0, d_c};

   // ---------------- driver tasks ----------------
   task automatic goto(input int c);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < c);
   endtask

   task automatic exp_push(input int inst, input int c, input string nm,
                           input int x, input int y, input int d, input logic [5:0] f);
      rec_t r;
      r.inst = inst;
      r.cyc  = c;
      r.name = nm;
      r.x    = 10'(x);
      r.y    = 10'(y);
      r.div  = 2'(d);
      r.f    = f;
      exp_q.push_back(r);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      rec_t       r;
      bit         cov [3];
      logic [27:0] act, expv;
      for (int i = 0; i < 3; i++) cov[i] = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         r = exp_q.pop_front();
         n_cmp++;
         act  = {x_w[r.inst], y_w[r.inst], d_w[r.inst], vid_w[r.inst], hs_w[r.inst],
                 vs_w[r.inst], lt_w[r.inst], ft_w[r.inst], pe_w[r.inst]};
         expv = {r.x, r.y, r.div, r.f};
         if (r.cyc != cyc) begin
            n_err++;
            $display("FAIL %s: expected at cyc %0d but not sampled until cyc %0d", r.name, r.cyc, cyc);
         end else if (act !== expv) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got x=%0d y=%0d div=%0d vid/hs/vs/lt/ft/pe=%b, need x=%0d y=%0d div=%0d vid/hs/vs/lt/ft/pe=%b",
                     r.name, cyc, act[27:18], act[17:8], act[7:6], act[5:0],
                     r.x, r.y, r.div, r.f);
         end
         if (r.f[2] || r.f[1]) cov[r.inst] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         if ((lt_w[i] === 1'b1 || ft_w[i] === 1'b1) && !cov[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_tick inst=%0d cyc=%0d: got lt=%b ft=%b, need 0 0 (x=%0d y=%0d)",
                     i, cyc, lt_w[i], ft_w[i], x_w[i], y_w[i]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         en[i]    = 1'b1;
      end

      exp_push(0, 2, "a_reset", 799, 524, 0, 6'b011000);
      exp_push(1, 2, "b_reset", 7, 5, 0, 6'b000001);
      exp_push(2, 2, "c_reset", 23, 17, 0, 6'b011000);

      // Default timing: startup, one line of hsync/blank edges, en freeze at x=300.
      exp_push(0, 12,   "a_pre_pix",          799, 524, 2, 6'b011000);
      exp_push(0, 13,   "a_first_pix_en",     799, 524, 3, 6'b011001);
      exp_push(0, 14,   "a_first_frame_tick", 0,   0,   0, 6'b111110);
      exp_push(0, 15,   "a_tick_one_clk",     0,   0,   1, 6'b111000);
      exp_push(0, 2570, "a_x639_visible",     639, 0,   0, 6'b111000);
      exp_push(0, 2574, "a_x640_blank",       640, 0,   0, 6'b011000);
      exp_push(0, 2634, "a_x655_pre_hs",      655, 0,   0, 6'b011000);
      exp_push(0, 2638, "a_x656_hs_on",       656, 0,   0, 6'b001000);
      exp_push(0, 3018, "a_x751_hs_last",     751, 0,   0, 6'b001000);
      exp_push(0, 3022, "a_x752_hs_off",      752, 0,   0, 6'b011000);
      exp_push(0, 3214, "a_line_tick_y1",     0,   1,   0, 6'b111100);
      exp_push(0, 4414, "a_x300",             300, 1,   0, 6'b111000);
      exp_push(0, 4430, "a_frozen",           300, 1,   1, 6'b111000);
      exp_push(0, 4454, "a_resume_pix_en",    300, 1,   3, 6'b111001);
      exp_push(0, 4455, "a_x301",             301, 1,   0, 6'b111000);
      exp_push(0, 6451, "a_line_tick_y2",     0,   2,   0, 6'b111100);
      exp_push(0, 6460, "a_reset_again",      799, 524, 0, 6'b011000);

      goto(10);
      rst_n[0] = 1'b1;
      goto(4415);
      en[0] = 1'b0;
      goto(4452);
      en[0] = 1'b1;
      goto(6460);
      rst_n[0] = 1'b0;

      // Tiny raster, CLK_DIV=1, active-high syncs: 8-clk lines, 48-clk frames.
      for (int n = 0; n <= 12; n++) begin
         exp_push(1, 7001 + 8 * n, "b_line_tick", 0, n % 6, 0,
                  {((n % 6) < 3), 1'b0, ((n % 6) == 4), 1'b1, ((n % 6) == 0), 1'b1});
         if (n == 0) begin
            exp_push(1, 7002, "b_x1", 1, 0, 0, 6'b100001);
            exp_push(1, 7004, "b_x3", 3, 0, 0, 6'b100001);
            exp_push(1, 7005, "b_x4", 4, 0, 0, 6'b000001);
            exp_push(1, 7006, "b_x5", 5, 0, 0, 6'b010001);
            exp_push(1, 7007, "b_x6", 6, 0, 0, 6'b010001);
            exp_push(1, 7008, "b_x7", 7, 0, 0, 6'b000001);
         end
      end
      exp_push(1, 7100, "b_reset_again", 7, 5, 0, 6'b000001);

      goto(7000);
      rst_n[1] = 1'b1;
      goto(7100);
      rst_n[1] = 1'b0;

      // Small raster, CLK_DIV=2: run into hsync+vsync, reset mid-frame, restart.
      exp_push(2, 8001, "c_first_pix_en", 23, 17, 1, 6'b011001);
      for (int n = 0; n <= 15; n++) begin
         exp_push(2, 8002 + 48 * n, "c_line_tick", 0, n, 0,
                  {(n < 12), 1'b1, !(n == 14 || n == 15), 1'b1, (n == 0), 1'b0});
         if (n == 13) exp_push(2, 8672, "c_y13_last_px", 23, 13, 0, 6'b011000);
      end
      exp_push(2, 8761, "c_pre_reset",       19, 15, 1, 6'b000001);
      exp_push(2, 8762, "c_async_reset",     23, 17, 0, 6'b011000);
      exp_push(2, 8801, "c_restart_pix_en",  23, 17, 1, 6'b011001);
      exp_push(2, 8802, "c_restart_tick",    0,  0,  0, 6'b111110);

      goto(8000);
      rst_n[2] = 1'b1;
      goto(8762);
      rst_n[2] = 1'b0;
      goto(8800);
      rst_n[2] = 1'b1;
      goto(8820);

      // ---------------- final report ----------------
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         rec_t r;
         r = exp_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL %s: never sampled, needed at cyc %0d (run ended at cyc %0d)", r.name, r.cyc, cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the pong display path. It generalises the fixed 640x480 sync logic in the pong top to any resolution, porch set, sync polarity and system-to-pixel clock ratio. It produces hsync/vsync, a video-active flag, pixel coordinates and line/frame strobes for the object and RGB logic downstream. All outputs are registered and mutually aligned.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=1; 4 gives 25 MHz from 100 MHz)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level
- CW, 10, coordinate width; 2^CW >= max(H_TOTAL, V_TOTAL)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes all timing state
- pix_en  out  1  pixel strobe, combinational: en && div_cnt == CLK_DIV-1
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_on  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- x  out  CW  current pixel column
- y  out  CW  current line
- line_tick  out  1  one-clk pulse when x becomes 0
- frame_tick  out  1  one-clk pulse when (x,y) becomes (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL similarly (default 525).
- div_cnt counts 0..CLK_DIV-1 while en=1, wraps to 0; holds while en=0. For CLK_DIV=1 it is constant 0 and pix_en = en.
- On each pix_en: x increments; at x = H_TOTAL-1 it wraps to 0 and y increments; at y = V_TOTAL-1 with x wrapping, y wraps to 0.
- hsync asserted while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751); vsync asserted while V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- hsync, vsync and video_on are registered from next-state x/y and always match the current x/y in the same cycle.
- line_tick/frame_tick are registered; high only in the single clk where the new x=0 / (0,0) first appears.
- en=0: x, y, div_cnt, hsync, vsync and video_on hold; ticks and pix_en are 0.

## Timing
- Reset (async assert, all outputs immediately): div_cnt=0, x=H_TOTAL-1 (799), y=V_TOTAL-1 (524), video_on=0, hsync=!HS_POL, vsync=!VS_POL, line_tick=0, frame_tick=0.
- Reset release is synchronous to clk. With en=1, pix_en first rises on clk edge CLK_DIV-1 after release. On the following edge x=0, y=0, video_on=1 and line_tick=frame_tick=1.
- Latency: x/y/sync/video_on change 1 clk after the pix_en cycle.
- hsync pulse = H_SYNC*CLK_DIV clks; line period = H_TOTAL*CLK_DIV clks; frame period = H_TOTAL*V_TOTAL*CLK_DIV clks.
- Reset asserted mid-frame returns all state to reset values within the same cycle. No partial-frame recovery.
- en toggling mid-line resumes from the held div_cnt phase; no pixel is skipped or repeated.

## Test plan
- Reset then en=1, defaults -> outputs (799,524,0,1,1) during reset; frame_tick at clk 4 after release with x=0, y=0, video_on=1.
- Free run one full line -> hsync low for exactly 384 clks starting the clk x=656; video_on falls at x=640; line_tick every 3200 clks.
- Free run two frames -> vsync low for 2 lines (y=490,491); frame_tick period exactly 1,680,000 clks; y never exceeds 524.
- en low for 37 clks mid-line at x=300 -> x, sync and div_cnt frozen, pix_en=0. After en rises, x=301 appears after the remaining divider phase completes.
- Assert reset at x=700, y=491 -> immediately x=799, y=524, hsync=1, vsync=1. After release, restart exactly as in the first scenario.
- Params CLK_DIV=1, H/V=4/1/2/1 and 3/1/1/1, HS_POL=VS_POL=1 -> pix_en constant; 8-clk line; hsync high at x=5,6; frame_tick every 48 clks.
